// File: rtl/async_fifo_pkg.sv
// Shared helpers for the asynchronous FIFO pointer blocks: Gray conversion
// and the depth rule. Functions operate on a wide word; callers size-cast.
package async_fifo_pkg;

    localparam int PTR_MAX_W = 32;

    function automatic int unsigned fifo_depth(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // XOR prefix from the MSB; zero-extended inputs convert correctly at any width.
    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
        logic [PTR_MAX_W-1:0] b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/async_fifo_wptr_full_if.sv
// Write-side request/status bundle of the asynchronous FIFO.
interface async_fifo_wptr_full_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                  w_en;
    logic                  wr_accept;
    logic [ADDR_WIDTH-1:0] waddr;
    logic                  full;
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   wr_level;
    logic                  overflow;

    modport master (
        output w_en,
        input  wr_accept, waddr, full, almost_full, wr_level, overflow
    );

    modport slave (
        input  w_en,
        output wr_accept, waddr, full, almost_full, wr_level, overflow
    );
endinterface

// File: rtl/gray_ptr_counter.sv
// Binary + Gray pointer pair with increment enable; shared by the write-full
// and read-empty blocks. Next-state values are exposed for flag lookahead.
module gray_ptr_counter
    import async_fifo_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-2:0] addr,
    output logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin_next,
    output logic [WIDTH-1:0] gray_next
);

    logic [WIDTH-1:0] bin;

    always_comb begin
        bin_next  = bin + WIDTH'(inc);
        gray_next = WIDTH'(bin2gray(PTR_MAX_W'(bin_next)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin  <= '0;
            gray <= '0;
        end else begin
            bin  <= bin_next;
            gray <= gray_next;
        end
    end

    assign addr = bin[WIDTH-2:0];

endmodule

// File: rtl/async_fifo_wptr_full.sv
// Write-domain pointer and full/almost-full/level/overflow stage of the
// asynchronous FIFO; consumes the read pointer already synchronized to clk.
module async_fifo_wptr_full
    import async_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH         = 4,
    parameter int ALMOST_FULL_MARGIN = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    async_fifo_wptr_full_if.slave  wr,
    input  logic [ADDR_WIDTH:0]    rptr_sync_gray,
    output logic [ADDR_WIDTH:0]    wptr_gray
);

    localparam int          PW        = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH     = fifo_depth(ADDR_WIDTH);
    localparam logic [PW-1:0] AF_THRESH = PW'(DEPTH - ALMOST_FULL_MARGIN);

    logic          push;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] rbin;
    logic [PW-1:0] level_next;
    logic [PW-1:0] rptr_full_pattern;
    logic          full_next;
    logic          almost_full_next;

    assign push         = wr.w_en & ~wr.full;
    assign wr.wr_accept = push;

    gray_ptr_counter #(
        .WIDTH (PW)
    ) u_wptr (
        .clk       (clk),
        .rst       (rst),
        .inc       (push),
        .addr      (wr.waddr),
        .gray      (wptr_gray),
        .bin_next  (wbin_next),
        .gray_next (wgray_next)
    );

    // Full means the writer is exactly one lap ahead: top two Gray bits differ.
    always_comb begin
        rptr_full_pattern = {~rptr_sync_gray[PW-1:PW-2], rptr_sync_gray[PW-3:0]};
        full_next         = (wgray_next == rptr_full_pattern);
        rbin              = PW'(gray2bin(PTR_MAX_W'(rptr_sync_gray)));
        level_next        = wbin_next - rbin;
        almost_full_next  = (level_next >= AF_THRESH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr.full        <= 1'b0;
            wr.almost_full <= 1'b0;
            wr.wr_level    <= '0;
            wr.overflow    <= 1'b0;
        end else begin
            wr.full        <= full_next;
            wr.almost_full <= almost_full_next;
            wr.wr_level    <= level_next;
            wr.overflow    <= wr.w_en & wr.full;
        end
    end

endmodule

// File: tb/tb_async_fifo_wptr_full.sv
// Directed bench for async_fifo_wptr_full (ADDR_WIDTH=4, margin 2):
// vector table for fill/overflow/release plus wrap and async-reset sequences.
module tb_async_fifo_wptr_full;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] rptr_sync_gray = '0;
    logic [4:0] wptr_gray;

    async_fifo_wptr_full_if #(.ADDR_WIDTH(4)) wif ();

    async_fifo_wptr_full #(
        .ADDR_WIDTH         (4),
        .ALMOST_FULL_MARGIN (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .wr             (wif),
        .rptr_sync_gray (rptr_sync_gray),
        .wptr_gray      (wptr_gray)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       w_en;
        logic [4:0] rptr;
        logic       acc;
        logic       full;
        logic       af;
        logic [4:0] lvl;
        logic [4:0] gray;
        logic [3:0] waddr;
        logic       ovf;
    } vec_t;

    vec_t vt[27];

    function automatic logic [4:0] g5(input int i);
        logic [4:0] b;
        b = 5'(i);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gray"},  32'(wptr_gray),       32'd0);
        chk({tag, "_waddr"}, 32'(wif.waddr),       32'd0);
        chk({tag, "_full"},  32'(wif.full),        32'd0);
        chk({tag, "_af"},    32'(wif.almost_full), 32'd0);
        chk({tag, "_lvl"},   32'(wif.wr_level),    32'd0);
        chk({tag, "_ovf"},   32'(wif.overflow),    32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        wif.w_en = 1'b0;
        rptr_sync_gray = '0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        // Fill from empty with read pointer parked at 0.
        for (int i = 0; i < 16; i++) begin
            vt[i] = '{1'b1, 5'b00000, 1'b1, (i == 15), (i + 1 >= 14),
                      5'(i + 1), g5(i + 1), 4'(i + 1), 1'b0};
        end
        for (int i = 16; i < 19; i++) begin
            vt[i] = '{1'b1, 5'b00000, 1'b0, 1'b1, 1'b1, 5'd16, 5'b11000, 4'd0, 1'b1};
        end
        vt[19] = '{1'b0, 5'b00000, 1'b0, 1'b1, 1'b1, 5'd16, 5'b11000, 4'd0, 1'b0};
        vt[20] = '{1'b0, 5'b00110, 1'b0, 1'b0, 1'b0, 5'd12, 5'b11000, 4'd0, 1'b0};
        vt[21] = '{1'b1, 5'b00110, 1'b1, 1'b0, 1'b0, 5'd13, 5'b11001, 4'd1, 1'b0};
        vt[22] = '{1'b1, 5'b00110, 1'b1, 1'b0, 1'b1, 5'd14, 5'b11011, 4'd2, 1'b0};
        vt[23] = '{1'b1, 5'b00110, 1'b1, 1'b0, 1'b1, 5'd15, 5'b11010, 4'd3, 1'b0};
        vt[24] = '{1'b1, 5'b00110, 1'b1, 1'b1, 1'b1, 5'd16, 5'b11110, 4'd4, 1'b0};
        // Write while full as the read pointer advances: refused, full clears.
        vt[25] = '{1'b1, 5'b00111, 1'b0, 1'b0, 1'b1, 5'd15, 5'b11110, 4'd4, 1'b1};
        vt[26] = '{1'b1, 5'b00111, 1'b1, 1'b1, 1'b1, 5'd16, 5'b11111, 4'd5, 1'b0};

        // Reset held with w_en high.
        wif.w_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("rst_hold");
        #2;
        rst = 1'b0;
        #1;
        chk("rel_waddr", 32'(wif.waddr), 32'd0);
        chk("rel_accept", 32'(wif.wr_accept), 32'd1);

        for (int v = 0; v < 27; v++) begin
            @(negedge clk);
            wif.w_en = vt[v].w_en;
            rptr_sync_gray = vt[v].rptr;
            #1;
            chk($sformatf("v%0d_accept", v), 32'(wif.wr_accept), 32'(vt[v].acc));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_full", v),  32'(wif.full),        32'(vt[v].full));
            chk($sformatf("v%0d_af", v),    32'(wif.almost_full), 32'(vt[v].af));
            chk($sformatf("v%0d_lvl", v),   32'(wif.wr_level),    32'(vt[v].lvl));
            chk($sformatf("v%0d_gray", v),  32'(wptr_gray),       32'(vt[v].gray));
            chk($sformatf("v%0d_waddr", v), 32'(wif.waddr),       32'(vt[v].waddr));
            chk($sformatf("v%0d_ovf", v),   32'(wif.overflow),    32'(vt[v].ovf));
        end

        // Wrap: read pointer trails two entries behind through 40 writes.
        do_reset();
        for (int k = 0; k < 40; k++) begin
            logic [4:0] prev;
            @(negedge clk);
            wif.w_en = 1'b1;
            rptr_sync_gray = (k >= 2) ? g5(k - 2) : 5'b00000;
            prev = wptr_gray;
            @(posedge clk);
            #1;
            chk($sformatf("wrap%0d_gray", k),  32'(wptr_gray), 32'(g5((k + 1) % 32)));
            chk($sformatf("wrap%0d_waddr", k), 32'(wif.waddr), 32'((k + 1) % 16));
            chk($sformatf("wrap%0d_1bit", k),  32'($countones(wptr_gray ^ prev)), 32'd1);
            chk($sformatf("wrap%0d_full", k),  32'(wif.full), 32'd0);
        end

        // Async reset between edges after 7 writes.
        do_reset();
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            wif.w_en = 1'b1;
        end
        @(negedge clk);
        wif.w_en = 1'b0;
        #1;
        chk("pre_arst_gray", 32'(wptr_gray), 32'(g5(7)));
        chk("pre_arst_lvl", 32'(wif.wr_level), 32'd7);
        #1;
        rst = 1'b1;
        #1;
        chk_all_zero("arst");
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
